keypad_scan: RTL and testbench

Parametrised matrix-keypad scanner, the successor to the fixed 4x4 keypad driver. Runs on the system clock with an internal scan-rate divider. Drives the columns and samples the rows, debounces whole-matrix frames, and rejects multi-key ghosting. Buffers key-press codes in a small FIFO with a valid/ready handshake, feeding the display and control logic.

---
 rtl/keypad_scan.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
//------------------------------------------------------------------------------
// keypad_scan
//   Matrix keypad scanner with whole-frame debounce, ghost rejection and a
//   first-word-fall-through key-code FIFO.
//
//   Optional feature macro: KEYPAD_SCAN_REPEAT_EN (auto-repeat of a held key).
//
//   Ports:
//     clk         system clock
//     reset       synchronous, active-high reset
//     fila        row inputs, active-low
//     col         column drive, active-low one-hot
//     key_code    FIFO head code = row*COLS + column
//     key_valid   FIFO non-empty
//     key_ready   consumer pops the head when key_valid && key_ready
//     fifo_count  number of entries held
//     overflow    sticky flag: a press was dropped because the FIFO was full
//     key_held    debounced state has exactly one key down
//------------------------------------------------------------------------------
module keypad_scan #(
   parameter int ROWS          = 4,
   parameter int COLS          = 4,
   parameter int SCAN_DIV      = 500_000,
   parameter int DEBOUNCE      = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int REPEAT_FRAMES = 50
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ROWS-1:0]                 fila,
   output logic [COLS-1:0]                 col,
   output logic [$clog2(ROWS*COLS)-1:0]    key_code,
   output logic                            key_valid,
   input  logic                            key_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            overflow,
   output logic                            key_held
);

   localparam int NK = ROWS * COLS;
   localparam int KW = $clog2(NK);
   localparam int CW = $clog2(COLS);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] col_idx_q, col_idx_d;
   logic [NK-1:0] frame_q, frame_d;
   logic [NK-1:0] prev_q, prev_d;
   logic [NK-1:0] deb_q, deb_d;
   logic          frame_end_q, frame_end_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [KW-1:0] mem_q [FIFO_DEPTH];
   logic [KW-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [NW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [KW-1:0] key_code_q, key_code_d;

   logic          press, repeat_push, push_req, pop, full, do_push;
   logic [KW-1:0] push_code;

   // Frame bit index is c*ROWS + r; the key code is r*COLS + c.
   function automatic logic [KW-1:0] code_of(input logic [NK-1:0] v);
      code_of = '0;
      for (int unsigned i = 0; i < NK; i++)
         if (v[i]) code_of = KW'((i % ROWS) * COLS + i / ROWS);
   endfunction

   // Scan divider, column stepping and frame capture
   always_comb begin
      div_d       = div_q + DW'(1);
      col_idx_d   = col_idx_q;
      frame_d     = frame_q;
      frame_end_d = 1'b0;
      if (div_q == DW'(SCAN_DIV - 1)) begin
         div_d = '0;
         frame_d[int'(col_idx_q) * ROWS +: ROWS] = ~fila;
         if (col_idx_q == CW'(COLS - 1)) begin
            col_idx_d   = '0;
            frame_end_d = 1'b1;
         end else begin
            col_idx_d = col_idx_q + CW'(1);
         end
      end
   end

   // Whole-frame debounce and press detection, one cycle after the frame ends
   always_comb begin
      prev_d = prev_q;
      stab_d = stab_q;
      deb_d  = deb_q;
      press  = 1'b0;
      if (frame_end_q) begin
         prev_d = frame_q;
         if (frame_q == prev_q) begin
            if (stab_q != SW'(DEBOUNCE)) stab_d = stab_q + SW'(1);
         end else begin
            stab_d = '0;
         end
         if (stab_d == SW'(DEBOUNCE)) begin
            deb_d = frame_q;
            // only a clean 0 -> 1 key transition counts; chords never push
            press = $onehot(frame_q) && (deb_q == '0);
         end
      end
   end

   assign key_held = $onehot(deb_q);

`ifdef KEYPAD_SCAN_REPEAT_EN
   localparam int RW = $clog2(REPEAT_FRAMES + 1);
   logic [RW-1:0] rep_q, rep_d;

   always_comb begin
      rep_d       = rep_q;
      repeat_push = 1'b0;
      if (frame_end_q) begin
         if ((deb_d != deb_q) || !key_held) begin
            rep_d = '0;
         end else if (rep_q + RW'(1) == RW'(REPEAT_FRAMES)) begin
            repeat_push = 1'b1;
            rep_d       = RW'(REPEAT_FRAMES / 2);
         end else begin
            rep_d = rep_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rep_q <= '0;
      else       rep_q <= rep_d;
   end
`else
   assign repeat_push = 1'b0;
`endif

   // Key-code FIFO
   always_comb begin
      push_req   = press | repeat_push;
      push_code  = press ? code_of(frame_q) : code_of(deb_q);
      pop        = key_ready && (count_q != '0);
      full       = (count_q == NW'(FIFO_DEPTH));
      do_push    = push_req && (!full || pop);
      overflow_d = overflow_q | (push_req && full && !pop);
      mem_d      = mem_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      count_d    = count_q;
      key_code_d = key_code_q;
      if (do_push) begin
         mem_d[wr_q] = push_code;
         wr_d        = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      if (do_push && !pop)      count_d = count_q + NW'(1);
      else if (pop && !do_push) count_d = count_q - NW'(1);
      // Registered head: bypass the incoming code when it lands at the new
      // read slot, otherwise hold the last code once the FIFO drains.
      if (count_d != '0)
         key_code_d = (do_push && (wr_q == rd_d)) ? push_code : mem_q[rd_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q       <= '0;
         col_idx_q   <= '0;
         frame_q     <= '0;
         prev_q      <= '0;
         deb_q       <= '0;
         frame_end_q <= 1'b0;
         stab_q      <= '0;
         mem_q       <= '{default: '0};
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         key_code_q  <= '0;
      end else begin
         div_q       <= div_d;
         col_idx_q   <= col_idx_d;
         frame_q     <= frame_d;
         prev_q      <= prev_d;
         deb_q       <= deb_d;
         frame_end_q <= frame_end_d;
         stab_q      <= stab_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         key_code_q  <= key_code_d;
      end
   end

   assign col        = ~(COLS'(1) << col_idx_q);
   assign key_code   = key_code_q;
   assign key_valid  = (count_q != '0);
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scan.sv
//------------------------------------------------------------------------------
// tb_keypad_scan
//   Directed bench for keypad_scan with ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2,
//   FIFO_DEPTH=4, REPEAT_FRAMES=4. A key matrix model pulls a row low while
//   its pressed key's column is driven. One frame is 16 clocks; frame
//   boundaries are tracked by a cycle counter cleared by reset.
//------------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int FRAME = 4 * COLS;

`ifdef KEYPAD_SCAN_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic                 clk;
   logic                 reset;
   logic [ROWS-1:0]      fila;
   logic [COLS-1:0]      col;
   logic [3:0]           key_code;
   logic                 key_valid;
   logic                 key_ready;
   logic [2:0]           fifo_count;
   logic                 overflow;
   logic                 key_held;
   logic [ROWS*COLS-1:0] keys;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;
   int unsigned t0;
   int unsigned npush;
   int unsigned offs [8];

   keypad_scan #(
      .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2),
      .FIFO_DEPTH(4), .REPEAT_FRAMES(4)
   ) dut (
      .clk(clk), .reset(reset), .fila(fila), .col(col),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .fifo_count(fifo_count), .overflow(overflow), .key_held(key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   always_comb begin
      fila = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!col[c] && keys[r*COLS+c]) fila[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   // advance to the n-th following frame boundary
   task automatic wait_frames(input int n);
      repeat (n) begin
         @(negedge clk);
         while (cyc % FRAME != 0) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      keys      = '0;
      key_ready = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_col", 32'(col), 32'hE);
      chk("rst_valid", 32'(key_valid), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_code", 32'(key_code), 0);
      chk("rst_held", 32'(key_held), 0);
      reset = 1'b0;
   endtask

   task automatic release_and_drain(input string tag, input int unsigned n);
      keys = '0;
      wait_frames(4);
      chk(tag, 32'(fifo_count), n);
      key_ready = 1'b1;
      repeat (6) @(negedge clk);
      key_ready = 1'b0;
      chk("drain_empty", 32'(key_valid), 0);
      chk("release_held", 32'(key_held), 0);
      wait_frames(1);
   endtask

   task automatic press_release(input int code);
      keys[code] = 1'b1;
      wait_frames(3);
      keys = '0;
      wait_frames(3);
   endtask

   task automatic pop_expect(input string tag, input int unsigned code);
      chk(tag, 32'(key_code), code);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   initial begin
      keys = '0; key_ready = 1'b0; reset = 1'b1;

      // 1: reset values and column stepping
      do_reset();
      repeat (3) @(negedge clk);
      chk("col_hold0", 32'(col), 32'hE);
      @(negedge clk);
      chk("col_step1", 32'(col), 32'hD);
      repeat (4) @(negedge clk);
      chk("col_step2", 32'(col), 32'hB);
      repeat (4) @(negedge clk);
      chk("col_step3", 32'(col), 32'h7);
      repeat (4) @(negedge clk);
      chk("col_wrap", 32'(col), 32'hE);

      // 2: single press of key 9 (row 2, column 1) held 8 frames
      keys[9] = 1'b1;
      wait_frames(3);
      chk("t2_no_early", 32'(key_valid), 0);
      @(negedge clk);
      chk("t2_valid", 32'(key_valid), 1);
      chk("t2_code", 32'(key_code), 9);
      chk("t2_held", 32'(key_held), 1);
      chk("t2_count", 32'(fifo_count), 1);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      chk("t2_pop_valid", 32'(key_valid), 0);
      chk("t2_pop_count", 32'(fifo_count), 0);
      chk("t2_code_hold", 32'(key_code), 9);
      wait_frames(5);
      chk("t2_one_push", 32'(fifo_count), REP ? 1 : 0);
      release_and_drain("t2_release", REP ? 2 : 0);

      // 3: bounce on key 9, then steady
      for (int i = 0; i < 5; i++) begin
         keys[9] = (i % 2 == 0);
         wait_frames(1);
      end
      chk("t3_bounce_none", 32'(key_valid), 0);
      wait_frames(2);
      chk("t3_no_early", 32'(key_valid), 0);
      wait_frames(1);
      chk("t3_count", 32'(fifo_count), 1);
      chk("t3_code", 32'(key_code), 9);
      wait_frames(1);
      release_and_drain("t3_release", REP ? 2 : 1);

      // 4: ghosting, keys 0 and 5 together
      keys[0] = 1'b1; keys[5] = 1'b1;
      wait_frames(6);
      chk("t4_chord_none", 32'(key_valid), 0);
      chk("t4_chord_held", 32'(key_held), 0);
      keys[5] = 1'b0;
      wait_frames(4);
      chk("t4_partial_none", 32'(key_valid), 0);
      chk("t4_partial_held", 32'(key_held), 1);
      release_and_drain("t4_release", 0);
      keys[5] = 1'b1;
      wait_frames(4);
      chk("t4_new_count", 32'(fifo_count), 1);
      chk("t4_new_code", 32'(key_code), 5);
      chk("t4_new_held", 32'(key_held), 1);
      release_and_drain("t4_new_release", 1);

      // 5: overflow
      press_release(1); press_release(2); press_release(3); press_release(4);
      chk("t5_full_count", 32'(fifo_count), 4);
      chk("t5_full_ovf", 32'(overflow), 0);
      press_release(6);
      chk("t5_ovf_count", 32'(fifo_count), 4);
      chk("t5_ovf_set", 32'(overflow), 1);
      pop_expect("t5_pop1", 1);
      pop_expect("t5_pop2", 2);
      pop_expect("t5_pop3", 3);
      pop_expect("t5_pop4", 4);
      chk("t5_empty", 32'(key_valid), 0);
      chk("t5_ovf_sticky", 32'(overflow), 1);

      // reset mid-debounce with pending entries
      press_release(7); press_release(8);
      chk("t5_pending", 32'(fifo_count), 2);
      keys[9] = 1'b1;
      wait_frames(2);
      do_reset();

      // 5b: fifth push coincides with a pop
      press_release(1); press_release(2); press_release(3); press_release(4);
      keys[6] = 1'b1;
      wait_frames(3);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      chk("t5b_count", 32'(fifo_count), 4);
      chk("t5b_ovf", 32'(overflow), 0);
      keys = '0;
      wait_frames(3);
      pop_expect("t5b_pop2", 2);
      pop_expect("t5b_pop3", 3);
      pop_expect("t5b_pop4", 4);
      pop_expect("t5b_pop6", 6);
      chk("t5b_empty", 32'(key_valid), 0);
      wait_frames(1);

      // 6: hold key 15 with the consumer always ready
      key_ready = 1'b1;
      keys[15]  = 1'b1;
      t0        = cyc;
      npush     = 0;
      for (int n = 0; n < 16 * FRAME; n++) begin
         @(negedge clk);
         if (key_valid) begin
            chk("t6_code", 32'(key_code), 15);
            if (npush < 8) offs[npush] = cyc - t0;
            npush++;
         end
      end
      chk("t6_pushes", npush, REP ? 6 : 1);
      chk("t6_first_at", offs[0], 3 * FRAME + 1);
      chk("t6_held", 32'(key_held), 1);
`ifdef KEYPAD_SCAN_REPEAT_EN
      chk("t6_first_repeat", offs[1], 7 * FRAME + 1);
      chk("t6_next_repeat", offs[2], 9 * FRAME + 1);
`endif
      key_ready = 1'b0;
      release_and_drain("t6_release", REP ? 1 : 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
